instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-cycle RISC-V core: owns the program counter, issues word reads to instruction memory over a req/gnt/rvalid handshake, and presents each returned instruction word with its PC on a valid/ready output consumed by the decoder. Handles control-flow redirects, including discarding an in-flight stale response. One outstanding memory request at most; one-entry output register.

## Interface
- AW, 32, address width
- DW, 32, instruction/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset (AW bits)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  request to instruction memory
- imem_addr  out  AW  word-aligned fetch address
- imem_gnt  in  1  request accepted (sampled with imem_req)
- imem_rvalid  in  1  read data valid, one per granted request
- imem_rdata  in  DW  read data
- redirect_valid  in  1  load new PC (branch/jump/trap), one-cycle pulse
- redirect_pc  in  AW  target PC
- instr_valid  out  1  instr/instr_pc/fetch_err valid
- instr_ready  in  1  decoder accepts beat
- instr  out  DW  fetched instruction word
- instr_pc  out  AW  PC of instr
- fetch_err  out  1  misaligned-target beat (see Configuration)

## Operation
- States: REQ, WAIT, HALT. Reset state REQ; pc = RESET_PC; kill = 0.
- REQ: imem_req = 1 when output slot free (!instr_valid || instr_ready); once asserted, held with stable imem_addr = pc until imem_gnt. On req&&gnt -> WAIT.
- WAIT: imem_req = 0. On imem_rvalid: if kill, drop data, kill <= 0, -> REQ; else load output register {instr <= rdata, instr_pc <= pc, fetch_err <= 0}, pc <= pc + 4 (mod 2^AW, wraps), -> REQ.
- Output register: instr_valid set on load, cleared on instr_valid && instr_ready; contents stable while valid && !ready. Request gating guarantees a response never lands in a full slot.
- Redirect (highest priority, any state): pc <= {redirect_pc[AW-1:2], 2'b00}; output register cleared (a beat handshaken in the same cycle counts as consumed); -> REQ.
  - In REQ without gnt: imem_req may drop; memory acts only on req&&gnt. If gnt in same cycle: kill <= 1, -> WAIT.
  - In WAIT without rvalid: kill <= 1, stay WAIT. With rvalid same cycle: data dropped, -> REQ.
- imem_addr[1:0] always 2'b00.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, fetch_err 0. Reset mid-transaction abandons it; late rvalid after reset release while in REQ is ignored.
- First imem_req: first rising edge after rst_n deasserts.
- Zero-wait memory (gnt same cycle as req, rvalid next cycle): instr_valid one cycle after rvalid; sustained throughput one instruction per 2 cycles.
- Redirect to first new request: next cycle (REQ) or cycle after stale rvalid (WAIT).

## Configuration
- INSTR_FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0] != 0 issues no memory request; next cycle emits one beat with fetch_err = 1, instr = 0, instr_pc = redirect_pc (unaligned); after it is consumed -> HALT (no requests) until next redirect. Killed in-flight response still dropped.
- Not defined: fetch_err tied 0; HALT unreachable; low PC bits silently cleared.

## Structure
- Package instr_fetch_pkg: state enum (REQ, WAIT, HALT), default RESET_PC, PC_INCR = 4.
- Sub-module fetch_pc_gen: pc register, +4 increment, redirect mux and alignment; FSM and output register stay in instr_fetch.

## Test plan
- Reset release, zero-wait memory, instr_ready = 1 -> imem_addr 0x0, 0x4, 0x8 every 2 cycles; instr_pc matches; instr = rdata.
- instr_ready low 5 cycles with beat at 0x10 -> instr_valid held, instr/instr_pc stable, imem_req stays 0; next request (0x14) in cycle ready rises.
- gnt delayed 3 cycles -> imem_req and imem_addr stable all 3 cycles; one beat out.
- Redirect to 0x100 while in WAIT for 0x20 -> 0x20 response discarded, next imem_addr 0x100, next beat instr_pc 0x100.
- Redirect coincident with rvalid, and pc 0xFFFF_FFFC fetch -> data dropped; wrap to 0x0000_0000.
- Macro defined, redirect to 0x102 -> no imem_req, beat fetch_err = 1, instr_pc 0x102, then HALT until redirect 0x200 resumes fetch.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // ready to issue a request
    S_WAIT = 2'd1,  // request granted, waiting for rvalid
    S_HALT = 2'd2   // parked after a misaligned-target beat
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of the instruction-memory port, the redirect input and
//               the decoder-facing valid/ready beat of the fetch stage.
//               master = fetch stage, slave = memory/decoder/branch side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;

  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;

  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          fetch_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, fetch_err,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, fetch_err,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Program counter of the fetch stage: reset value, +4 advance
//               on each accepted instruction, and the word-aligned redirect
//               target. Flags misaligned redirect targets only when
//               INSTR_FETCH_MISALIGN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
  import instr_fetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid_i,
  input  logic [AW-1:0] redirect_pc_i,
  input  logic          advance_i,
  output logic [AW-1:0] pc_o,
  output logic          misalign_o
);

  localparam logic [AW-1:0] c_RESET_PC_AL = {RESET_PC[AW-1:2], 2'b00};
  localparam logic [AW-1:0] c_INCR        = AW'(PC_INCR);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // Next PC: redirect target (low bits cleared) beats the sequential advance
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[AW-1:2], 2'b00};
    end else if (advance_i) begin
      pc_d = pc_q + c_INCR;  // wraps modulo 2^AW
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= c_RESET_PC_AL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

`ifdef INSTR_FETCH_MISALIGN_EN
  assign misalign_o = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
  // Low target bits are dropped silently in this build
  logic w_unused_lo;
  assign w_unused_lo = ^redirect_pc_i[1:0];
  assign misalign_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Issues one word read at a time over
//               req/gnt/rvalid, presents each returned word with its PC in a
//               one-entry valid/ready output register, and handles redirects
//               including discarding a stale in-flight response.
//               Optional: INSTR_FETCH_MISALIGN_EN reports misaligned redirect
//               targets as a fetch_err beat and then halts fetching.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_e  state_q, state_d;
  logic          kill_q, kill_d;    // in-flight response is stale
  logic          halt_q, halt_d;    // park in HALT once the stale response drains
  logic          run_q;             // first edge after reset has passed

  logic          valid_q, valid_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] ipc_q,   ipc_d;
  logic          err_q,   err_d;

  logic [AW-1:0] w_pc;
  logic          w_misalign;
  logic          w_free;
  logic          w_fire;
  logic          w_req;
  logic          w_grant;
  logic          w_load;
  logic          w_inflight;

  assign w_free   = !valid_q || bus.instr_ready;
  assign w_fire   = valid_q && bus.instr_ready;
  // Gating on a free slot guarantees a response never lands in a full register
  assign w_req    = run_q && (state_q == S_REQ) && w_free;
  assign w_grant  = w_req && bus.imem_gnt;
  assign w_load   = (state_q == S_WAIT) && bus.imem_rvalid && !kill_q;
  // A response is still owed to us after this cycle
  assign w_inflight = w_grant || ((state_q == S_WAIT) && !bus.imem_rvalid);

  fetch_pc_gen #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_pc_i    (bus.redirect_pc),
    .advance_i        (w_load),
    .pc_o             (w_pc),
    .misalign_o       (w_misalign)
  );

  // Next-state, kill tracking and output-register update; redirect overrides all
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    err_d   = err_q;

    if (w_fire) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (w_grant) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = halt_q ? S_HALT : S_REQ;
          if (!kill_q) begin
            valid_d = 1'b1;
            instr_d = bus.imem_rdata;
            ipc_d   = w_pc;
            err_d   = 1'b0;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (bus.redirect_valid) begin
      kill_d  = w_inflight;
      halt_d  = w_misalign;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (w_misalign) begin
        // Error beat replaces the fetch; no request is made for this target
        valid_d = 1'b1;
        instr_d = '0;
        ipc_d   = bus.redirect_pc;
        err_d   = 1'b1;
        state_d = w_inflight ? S_WAIT : S_HALT;
      end else begin
        state_d = w_inflight ? S_WAIT : S_REQ;
      end
    end
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      kill_q  <= 1'b0;
      halt_q  <= 1'b0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      halt_q  <= halt_d;
      run_q   <= 1'b1;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      err_q   <= err_d;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = w_pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.fetch_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: cycle tables for the
//               directed scenarios, then randomized memory/decoder/redirect
//               traffic checked against an expected-PC-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic clk;
  logic rst_n;

  instr_fetch_if #(.AW(32), .DW(32)) bus ();

  instr_fetch #(
    .AW       (32),
    .DW       (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

`ifdef INSTR_FETCH_MISALIGN_EN
  localparam logic [31:0] c_ODD_TGT = 32'h0000_0080;
`else
  localparam logic [31:0] c_ODD_TGT = 32'h0000_0083;  // low bits must be ignored
`endif

  function automatic logic [31:0] dv(input int n);
    return 32'hC0DE_0000 + 32'(n);
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic rd, input logic g, input logic rv,
                              input logic [31:0] rdat, input logic rdr,
                              input logic [31:0] rp, input logic erq,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei,
                              input logic ee);
    vec_t v;
    v.ready = rd; v.gnt = g; v.rvalid = rv; v.rdata = rdat;
    v.redir = rdr; v.rpc = rp; v.ereq = erq; v.eaddr = ea;
    v.evalid = ev; v.epc = ep; v.einstr = ei; v.eerr = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.instr_ready    = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    bus.instr_ready    = v.ready;
    bus.imem_gnt       = v.gnt;
    bus.imem_rvalid    = v.rvalid;
    bus.imem_rdata     = v.rdata;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
    #1;
    chk($sformatf("row%0d.req", idx),   32'(bus.imem_req),    32'(v.ereq));
    chk($sformatf("row%0d.addr", idx),  bus.imem_addr,        v.eaddr);
    chk($sformatf("row%0d.valid", idx), 32'(bus.instr_valid), 32'(v.evalid));
    chk($sformatf("row%0d.err", idx),   32'(bus.fetch_err),   32'(v.eerr));
    if (v.evalid) begin
      chk($sformatf("row%0d.pc", idx),    bus.instr_pc, v.epc);
      chk($sformatf("row%0d.instr", idx), bus.instr,    v.einstr);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      run_row(tbl[i], i);
    end
    tbl.delete();
  endtask

  // Random-phase model state
  logic        pend;
  int unsigned cnt;
  logic [31:0] exp_pc;
  int          beats;
  logic        wait_gnt;
  logic [31:0] held_addr;
  logic        hold;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1;
    // ---- Reset state, before the first edge after release ----
    chk("rst.req",   32'(bus.imem_req),    32'h0);
    chk("rst.addr",  bus.imem_addr,        32'h0);
    chk("rst.valid", 32'(bus.instr_valid), 32'h0);
    chk("rst.instr", bus.instr,            32'h0);
    chk("rst.pc",    bus.instr_pc,         32'h0);
    chk("rst.err",   32'(bus.fetch_err),   32'h0);

    // ---- Directed table: ready,gnt,rvalid,rdata,redir,rpc | req,addr,valid,pc,instr,err
    // Zero-wait streaming
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h0, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(0),  0,0, 0,32'h0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h4, 1,32'h0,dv(0),0));
    tbl.push_back(mk(1,0,1,dv(1),  0,0, 0,32'h4, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h8, 1,32'h4,dv(1),0));
    tbl.push_back(mk(1,0,1,dv(2),  0,0, 0,32'h8, 0,0,0,0));
    // Decoder stalls 5 cycles; a gnt without req is ignored
    tbl.push_back(mk(0,0,0,0,      0,0, 0,32'hC, 1,32'h8,dv(2),0));
    tbl.push_back(mk(0,1,0,0,      0,0, 0,32'hC, 1,32'h8,dv(2),0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,32'hC, 1,32'h8,dv(2),0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,32'hC, 1,32'h8,dv(2),0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,32'hC, 1,32'h8,dv(2),0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'hC, 1,32'h8,dv(2),0));
    tbl.push_back(mk(1,0,1,dv(3),  0,0, 0,32'hC, 0,0,0,0));
    // Grant delayed 3 cycles
    tbl.push_back(mk(1,0,0,0,      0,0, 1,32'h10, 1,32'hC,dv(3),0));
    tbl.push_back(mk(1,0,0,0,      0,0, 1,32'h10, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,      0,0, 1,32'h10, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h10, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(4),  0,0, 0,32'h10, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h14, 1,32'h10,dv(4),0));
    // Redirect while waiting: stale 0x14 data must vanish
    tbl.push_back(mk(1,0,0,0,      1,32'h100, 0,32'h14, 0,0,0,0));
    tbl.push_back(mk(1,0,1,32'hDEAD_0014, 0,0, 0,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(5),  0,0, 0,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h104, 1,32'h100,dv(5),0));
    // Redirect coincident with rvalid, then fetch at 0xFFFF_FFFC and wrap
    tbl.push_back(mk(1,0,1,32'hDEAD_0104, 1,32'hFFFF_FFFC, 0,32'h104, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'hFFFF_FFFC, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(6),  0,0, 0,32'hFFFF_FFFC, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h0, 1,32'hFFFF_FFFC,dv(6),0));
    tbl.push_back(mk(1,0,1,dv(7),  0,0, 0,32'h0, 0,0,0,0));
    // Redirect in REQ with grant in the same cycle; beat handshaken alongside
    tbl.push_back(mk(1,1,0,0,      1,32'h40, 1,32'h4, 1,32'h0,dv(7),0));
    tbl.push_back(mk(1,0,1,32'hDEAD_0004, 0,0, 0,32'h40, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h40, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(8),  0,0, 0,32'h40, 0,0,0,0));
    // Redirect with low target bits set
    tbl.push_back(mk(1,0,0,0,      1,c_ODD_TGT, 1,32'h44, 1,32'h40,dv(8),0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h80, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(9),  0,0, 0,32'h80, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,32'h84, 1,32'h80,dv(9),0));
    run_table();

`ifdef INSTR_FETCH_MISALIGN_EN
    // ---- Misaligned redirect: error beat, HALT, resume on next redirect ----
    do_reset();
    tbl.push_back(mk(1,0,0,0,      1,32'h102, 1,32'h0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,32'h100, 1,32'h102,32'h0,1));
    tbl.push_back(mk(0,1,0,0,      0,0, 0,32'h100, 1,32'h102,32'h0,1));
    tbl.push_back(mk(1,1,0,0,      0,0, 0,32'h100, 1,32'h102,32'h0,1));
    tbl.push_back(mk(1,1,0,0,      0,0, 0,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 0,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 0,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,      1,32'h200, 0,32'h100, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,      0,0, 1,32'h200, 0,0,0,0));
    tbl.push_back(mk(1,0,1,dv(10), 0,0, 0,32'h200, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0,      0,0, 1,32'h204, 1,32'h200,dv(10),0));
    run_table();
`endif

    // ---- Randomized traffic against the expected PC stream ----
    do_reset();
    pend      = 1'b0;
    cnt       = 0;
    exp_pc    = 32'h0;
    beats     = 0;
    wait_gnt  = 1'b0;
    held_addr = '0;
    hold      = 1'b0;
    hold_instr = '0;
    hold_pc    = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      bus.instr_ready    = ($urandom % 4) != 0;
      bus.redirect_valid = ($urandom % 50) == 0;
      if (($urandom % 4) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
      else                     bus.redirect_pc = $urandom;
`ifdef INSTR_FETCH_MISALIGN_EN
      bus.redirect_pc[1:0] = 2'b00;
`endif
      if (pend && cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memf(held_addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
      #1;
      bus.imem_gnt = ($urandom % 3) != 0;
      #1;
      if (bus.imem_req) begin
        chk("rnd.one_outstanding", 32'(pend), 32'h0);
        chk("rnd.addr_align", 32'(bus.imem_addr[1:0]), 32'h0);
      end
      if (wait_gnt && !bus.redirect_valid) begin
        chk("rnd.req_held",  32'(bus.imem_req), 32'h1);
        chk("rnd.addr_held", bus.imem_addr, held_addr);
      end
      if (hold) begin
        chk("rnd.hold_valid", 32'(bus.instr_valid), 32'h1);
        chk("rnd.hold_instr", bus.instr,    hold_instr);
        chk("rnd.hold_pc",    bus.instr_pc, hold_pc);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        chk("rnd.beat_pc",    bus.instr_pc, exp_pc);
        chk("rnd.beat_instr", bus.instr,    memf(exp_pc));
        chk("rnd.beat_err",   32'(bus.fetch_err), 32'h0);
        exp_pc = exp_pc + 32'd4;
        beats++;
      end
      if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
      hold       = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
      hold_instr = bus.instr;
      hold_pc    = bus.instr_pc;
      // Memory model: one response per grant, 1..3 cycles later
      if (bus.imem_rvalid)  pend = 1'b0;
      else if (pend)        cnt  = cnt - 1;
      wait_gnt = bus.imem_req && !bus.imem_gnt && !bus.redirect_valid;
      if (bus.imem_req && !bus.imem_gnt) held_addr = bus.imem_addr;
      if (bus.imem_req && bus.imem_gnt) begin
        pend      = 1'b1;
        cnt       = $urandom % 3;
        held_addr = bus.imem_addr;
      end
    end
    chk("rnd.progress", 32'(beats >= 200), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
